// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer: FSM state encoding and
// default master clock frequency.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJ    = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Free-running prescaler producing combinational 2 Hz / 1 Hz tick conditions
// and the registered blink toggle; a clear restarts the prescaler and phase.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic t2,
  output logic t1,
  output logic blink
);

  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  assign wrap = (cnt == LAST);
  // A clear in the wrap cycle swallows the tick so no strobe escapes it.
  assign t2   = wrap & ~clr;
  assign t1   = t2 & phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
      blink <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
      blink <= ~blink;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: synchronizes switches, edge-detects buttons and runs the
// RUN/PAUSED/ADJ FSM that issues one-cycle increment/clear strobes.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_sel,
  input  logic sw_adj,
  output logic sec_inc,
  output logic min_inc,
  output logic count_clr,
  output logic adjust,
  output logic select,
  output logic paused,
  output logic blink
);

  logic   adj_q1, adj_q2, sel_q1, sel_q2;
  logic   pause_q, clear_q;
  logic   pause_edge, clear_edge;
  logic   t2, t1;
  state_t state, state_next;
  logic   ret_paused, ret_next, ret_eff;
  logic   sec_next, min_next, clr_next, paused_next;

  assign pause_edge = btn_pause & ~pause_q;
  assign clear_edge = btn_reset & ~clear_q;
  assign select     = sel_q2;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_edge),
    .t2    (t2),
    .t1    (t1),
    .blink (blink)
  );

  // Strobes are decided from the current state; transitions take effect next cycle.
  always_comb begin
    state_next = state;
    ret_next   = ret_paused;
    ret_eff    = ret_paused ^ pause_edge;
    sec_next   = 1'b0;
    min_next   = 1'b0;
    clr_next   = 1'b0;
    if (clear_edge) begin
      clr_next = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (adj_q2) begin
            state_next = ST_ADJ;
            ret_next   = pause_edge;
          end else if (pause_edge) begin
            state_next = ST_PAUSED;
          end
          sec_next = t1 & ~pause_edge;
        end
        ST_PAUSED: begin
          if (adj_q2) begin
            state_next = ST_ADJ;
            ret_next   = ~pause_edge;
          end else if (pause_edge) begin
            state_next = ST_RUN;
          end
        end
        ST_ADJ: begin
          ret_next = ret_eff;
          if (!adj_q2) state_next = ret_eff ? ST_PAUSED : ST_RUN;
          if (t2 && !pause_edge) begin
            sec_next = ~sel_q2;
            min_next = sel_q2;
          end
        end
        default: begin
          state_next = ST_RUN;
          ret_next   = 1'b0;
        end
      endcase
    end
    paused_next = (state_next == ST_PAUSED) || ((state_next == ST_ADJ) && ret_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adj_q1     <= 1'b0;
      adj_q2     <= 1'b0;
      sel_q1     <= 1'b0;
      sel_q2     <= 1'b0;
      pause_q    <= 1'b0;
      clear_q    <= 1'b0;
      state      <= ST_RUN;
      ret_paused <= 1'b0;
      sec_inc    <= 1'b0;
      min_inc    <= 1'b0;
      count_clr  <= 1'b0;
      adjust     <= 1'b0;
      paused     <= 1'b0;
    end else begin
      adj_q1     <= sw_adj;
      adj_q2     <= adj_q1;
      sel_q1     <= sw_sel;
      sel_q2     <= sel_q1;
      pause_q    <= btn_pause;
      clear_q    <= btn_reset;
      state      <= state_next;
      ret_paused <= ret_next;
      sec_inc    <= sec_next;
      min_inc    <= min_next;
      count_clr  <= clr_next;
      adjust     <= (state_next == ST_ADJ);
      paused     <= paused_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with CLK_HZ=8
// (t2 every 4 cycles, t1 every 8 cycles).
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset, btn_pause, btn_reset, sw_sel, sw_adj;
  logic sec_inc, min_inc, count_clr, adjust, select, paused, blink;
  logic [5:0] outv;

  int t;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pause (btn_pause),
    .btn_reset (btn_reset),
    .sw_sel    (sw_sel),
    .sw_adj    (sw_adj),
    .sec_inc   (sec_inc),
    .min_inc   (min_inc),
    .count_clr (count_clr),
    .adjust    (adjust),
    .select    (select),
    .paused    (paused),
    .blink     (blink)
  );

  assign outv = {sec_inc, min_inc, count_clr, adjust, select, paused};

  function automatic logic [5:0] exp_v(input logic s, input logic m, input logic c,
                                       input logic a, input logic sl, input logic p);
    return {s, m, c, a, sl, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0d", tag, got, exp, t);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    reset = 1'b1; btn_pause = 1'b0; btn_reset = 1'b0; sw_sel = 1'b0; sw_adj = 1'b0;
    t = 0;
    repeat (3) step();
    check("reset_out", {26'd0, outv}, 32'd0);
    check("reset_blink", {31'd0, blink}, 32'd0);
    reset = 1'b0;
    t = 0;

    // 1: free running
    while (t < 24) begin
      step();
      check("run_out", {26'd0, outv}, {26'd0, exp_v(t % 8 == 0, 0, 0, 0, 0, 0)});
      check("run_blink", {31'd0, blink}, {31'd0, 1'((t / 4) % 2)});
    end

    // 2: pause held 20 cycles, then second press
    btn_pause = 1'b1;
    while (t < 64) begin
      step();
      if (t == 44) btn_pause = 1'b0;
      check("paused_out", {26'd0, outv}, {26'd0, exp_v(0, 0, 0, 0, 0, 1)});
    end
    btn_pause = 1'b1;
    while (t < 80) begin
      step();
      if (t == 65) btn_pause = 1'b0;
      check("resume_out", {26'd0, outv}, {26'd0, exp_v(t % 8 == 0, 0, 0, 0, 0, 0)});
    end

    // 3: adjust seconds, then minutes, then leave
    sw_adj = 1'b1;
    while (t < 96) begin
      step();
      if (t < 83) check("adj_lat", {26'd0, outv}, 32'd0);
      else check("adj_sec", {26'd0, outv}, {26'd0, exp_v(t % 4 == 0, 0, 0, 1, 0, 0)});
    end
    sw_sel = 1'b1;
    while (t < 112) begin
      step();
      check("adj_min", {26'd0, outv}, {26'd0, exp_v(0, (t >= 98) && (t % 4 == 0), 0, 1, t >= 98, 0)});
    end
    sw_adj = 1'b0;
    sw_sel = 1'b0;
    while (t < 128) begin
      step();
      if (t < 115) check("adj_exit", {26'd0, outv}, {26'd0, exp_v(0, 0, 0, 1, t == 113, 0)});
      else check("adj_run", {26'd0, outv}, {26'd0, exp_v(t % 8 == 0, 0, 0, 0, 0, 0)});
    end

    // 4: PAUSED -> ADJ, pause toggles return target, leave to RUN
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    check("p_enter", {26'd0, outv}, {26'd0, exp_v(0, 0, 0, 0, 0, 1)});
    step();
    sw_adj = 1'b1;
    check("p_hold", {26'd0, outv}, {26'd0, exp_v(0, 0, 0, 0, 0, 1)});
    while (t < 137) begin
      step();
      check("p_adj", {26'd0, outv}, {26'd0, exp_v((t >= 133) && (t % 4 == 0), 0, 0, t >= 133, 0, 1)});
    end
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    check("p_adj_tgl", {26'd0, outv}, {26'd0, exp_v(0, 0, 0, 1, 0, 0)});
    sw_adj = 1'b0;
    while (t < 160) begin
      step();
      if (t < 141) check("p_adj_exit", {26'd0, outv}, {26'd0, exp_v(t % 4 == 0, 0, 0, 1, 0, 0)});
      else check("p_run", {26'd0, outv}, {26'd0, exp_v(t % 8 == 0, 0, 0, 0, 0, 0)});
    end

    // 5: clear on the t1 cycle
    while (t < 167) begin
      step();
      check("pre_clr", {26'd0, outv}, {26'd0, exp_v(t % 8 == 0, 0, 0, 0, 0, 0)});
    end
    btn_reset = 1'b1;
    step();
    btn_reset = 1'b0;
    check("clr_pulse", {26'd0, outv}, {26'd0, exp_v(0, 0, 1, 0, 0, 0)});
    while (t < 180) begin
      step();
      check("post_clr", {26'd0, outv}, {26'd0, exp_v(t == 176, 0, 0, 0, 0, 0)});
    end

    // 6: clear and pause together, then reset mid-count
    btn_reset = 1'b1;
    btn_pause = 1'b1;
    step();
    btn_reset = 1'b0;
    btn_pause = 1'b0;
    check("clr_pause", {26'd0, outv}, {26'd0, exp_v(0, 0, 1, 0, 0, 0)});
    while (t < 196) begin
      step();
      check("clr_pause_run", {26'd0, outv}, {26'd0, exp_v(t == 189, 0, 0, 0, 0, 0)});
    end
    reset = 1'b1;
    step();
    check("rst_mid_out", {26'd0, outv}, 32'd0);
    check("rst_mid_blink", {31'd0, blink}, 32'd0);
    reset = 1'b0;
    while (t < 206) begin
      step();
      check("rst_run", {26'd0, outv}, {26'd0, exp_v(t == 205, 0, 0, 0, 0, 0)});
      check("rst_blink", {31'd0, blink}, {31'd0, 1'(((t - 197) / 4) % 2)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
